watch_segment_feeder: RTL and testbench



---
 rtl/watch_pkg.sv | 9 +
 rtl/watch_segment_feeder_if.sv | 23 ++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/watch_segment_feeder.sv | 110 +++++++++++
 tb/tb_watch_segment_feeder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/watch_pkg.sv
// Shared types and constants for the segment-display feeder.
package watch_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

    localparam int         NUM_REGS   = 9;
    localparam logic [3:0] BLINK_ADDR = 4'd8;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [7:0] SEG_DASH   = 8'hBF;
endpackage

// File: rtl/watch_segment_feeder_if.sv
// Snapshot input handshake plus the byte-wide Avalon-MM write port to the display slave.
interface watch_segment_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_digits;
    logic [7:0]  in_dp;
    logic [7:0]  in_blink;
    logic [3:0]  m_address;
    logic        m_write;
    logic [7:0]  m_writedata;
    logic        m_waitrequest;
    logic        busy;

    modport master (
        input  in_valid, in_digits, in_dp, in_blink, m_waitrequest,
        output in_ready, m_address, m_write, m_writedata, busy
    );

    modport slave (
        output in_valid, in_digits, in_dp, in_blink, m_waitrequest,
        input  in_ready, m_address, m_write, m_writedata, busy
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// Digit code to active-low a..g segments (bit0=a); 10 is a dash, 11-15 blank.
// Purely combinational; the decimal point is merged by the caller.
module bcd_to_seg7
    import watch_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK[6:0];
        case (code)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            4'd10:   seg = SEG_DASH[6:0];
            default: seg = SEG_BLANK[6:0];
        endcase
    end
endmodule

// File: rtl/watch_segment_feeder.sv
// Encodes a display snapshot and writes changed registers (0-7 digits, 8 blink) to the display slave.
// 1 cycle per skipped register, 2 per written one plus waitrequest stalls; snapshot accepted only when idle.
module watch_segment_feeder
    import watch_pkg::*;
#(
    parameter bit SKIP_UNCHANGED = 1'b1
) (
    input logic                    clk,
    input logic                    reset,
    watch_segment_feeder_if.master bus
);
    state_t      state;
    logic [3:0]  idx;
    logic [31:0] digits_q;
    logic [7:0]  dp_q;
    logic [7:0]  blink_q;
    logic [7:0]  shadow [NUM_REGS];
    logic [NUM_REGS-1:0] shadow_valid;

    logic        in_ready_q;
    logic        busy_q;
    logic        write_q;
    logic [3:0]  address_q;
    logic [7:0]  writedata_q;

    logic [6:0]  seg;
    logic [7:0]  cur_byte;
    logic        last_reg;
    logic        unchanged;

    bcd_to_seg7 u_seg (
        .code (digits_q[{idx[2:0], 2'b00} +: 4]),
        .seg  (seg)
    );

    assign cur_byte  = (idx == BLINK_ADDR) ? blink_q : {~dp_q[idx[2:0]], seg};
    assign last_reg  = (idx == BLINK_ADDR);
    assign unchanged = SKIP_UNCHANGED && shadow_valid[idx] && (shadow[idx] == cur_byte);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= 4'd0;
            write_q      <= 1'b0;
            address_q    <= 4'd0;
            writedata_q  <= 8'd0;
            shadow_valid <= '0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        digits_q   <= bus.in_digits;
                        dp_q       <= bus.in_dp;
                        blink_q    <= bus.in_blink;
                        idx        <= 4'd0;
                        state      <= SCAN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SCAN: begin
                    if (unchanged) begin
                        if (last_reg) begin
                            state      <= IDLE;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end else begin
                        address_q   <= idx;
                        writedata_q <= cur_byte;
                        write_q     <= 1'b1;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    // Address and data stay frozen until the slave drops waitrequest.
                    if (!bus.m_waitrequest) begin
                        shadow[idx]       <= writedata_q;
                        shadow_valid[idx] <= 1'b1;
                        write_q           <= 1'b0;
                        if (last_reg) begin
                            state      <= IDLE;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= SCAN;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    write_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.busy        = busy_q;
    assign bus.m_write     = write_q;
    assign bus.m_address   = address_q;
    assign bus.m_writedata = writedata_q;
endmodule

// File: tb/tb_watch_segment_feeder.sv
// Directed and randomized frames checked against a register-level model of the display shadow.
module tb_watch_segment_feeder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    watch_segment_feeder_if bus ();

    watch_segment_feeder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model of what the display slave currently holds.
    logic [7:0] m_shadow [9];
    bit         m_valid  [9];

    logic [11:0] obs_q[$];
    int busy_cnt, wait_cnt, a2_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] enc(input int k, input logic [31:0] d,
                                       input logic [7:0] dp, input logic [7:0] bl);
        logic [3:0] code;
        logic [7:0] b;
        if (k == 8) return bl;
        code = d[k*4 +: 4];
        case (code)
            4'd0: b = 8'hC0;  4'd1: b = 8'hF9;  4'd2: b = 8'hA4;  4'd3: b = 8'hB0;
            4'd4: b = 8'h99;  4'd5: b = 8'h92;  4'd6: b = 8'h82;  4'd7: b = 8'hF8;
            4'd8: b = 8'h80;  4'd9: b = 8'h90;  4'd10: b = 8'hBF;
            default: b = 8'hFF;
        endcase
        if (dp[k]) b[7] = 1'b0;
        return b;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 9; k++) m_valid[k] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    // mode: 0 no stall, 1 random waitrequest, 2 three stall cycles on the addr 2 write
    task automatic run_frame(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl,
                             input int mode, input bit rst_at4);
        logic [11:0] exp_q[$];
        logic [7:0]  b;
        bit          prev_stall, wr;
        logic [3:0]  prev_addr;
        logic [7:0]  prev_data;
        int          stall_left;
        obs_q.delete();
        busy_cnt = 0; wait_cnt = 0; a2_cnt = 0;
        prev_stall = 1'b0; prev_addr = 4'd0; prev_data = 8'd0;
        stall_left = (mode == 2) ? 3 : 0;
        for (int k = 0; k < 9; k++) begin
            b = enc(k, d, dp, bl);
            if (!(m_valid[k] && m_shadow[k] == b)) exp_q.push_back({k[3:0], b});
        end

        @(negedge clk);
        chk("idle_ready", bus.in_ready, 1);
        chk("idle_no_write", bus.m_write, 0);
        bus.in_valid = 1'b1; bus.in_digits = d; bus.in_dp = dp; bus.in_blink = bl;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_digits = $urandom; bus.in_dp = 8'($urandom); bus.in_blink = 8'($urandom);

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!bus.busy) break;
            busy_cnt++;
            if (prev_stall) begin
                chk("hold_write", bus.m_write, 1);
                chk("hold_addr", bus.m_address, prev_addr);
                chk("hold_data", bus.m_writedata, prev_data);
            end
            prev_stall = 1'b0;
            if (bus.m_write) begin
                if (bus.m_address == 4'd2) a2_cnt++;
                if (rst_at4 && bus.m_address == 4'd4) begin
                    reset = 1'b1;
                    bus.m_waitrequest = 1'b0;
                    @(negedge clk);
                    chk("abort_write", bus.m_write, 0);
                    chk("abort_busy", bus.busy, 0);
                    chk("abort_ready", bus.in_ready, 1);
                    chk("abort_prior_writes", obs_q.size(), 4);
                    reset = 1'b0;
                    clear_model();
                    return;
                end
                wr = 1'b0;
                if (mode == 1) wr = ($urandom_range(0, 3) == 0);
                if (mode == 2 && bus.m_address == 4'd2 && stall_left > 0) begin
                    wr = 1'b1;
                    stall_left--;
                end
                bus.m_waitrequest = wr;
                if (wr) begin
                    wait_cnt++;
                    prev_stall = 1'b1;
                    prev_addr  = bus.m_address;
                    prev_data  = bus.m_writedata;
                end else begin
                    obs_q.push_back({bus.m_address, bus.m_writedata});
                end
            end else begin
                bus.m_waitrequest = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
        end
        bus.m_waitrequest = 1'b0;
        chk("frame_done", bus.busy, 0);
        chk("write_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk("write_addr_data", obs_q[i], exp_q[i]);
        chk("busy_cycles", busy_cnt, 9 + exp_q.size() + wait_cnt);
        foreach (exp_q[i]) begin
            m_shadow[exp_q[i][11:8]] = exp_q[i][7:0];
            m_valid[exp_q[i][11:8]]  = 1'b1;
        end
    endtask

    initial begin
        logic [11:0] f1_exp [9];
        logic [31:0] d;
        logic [7:0]  dp, bl;
        f1_exp = '{12'h0F9, 12'h1A4, 12'h2BF, 12'h3B0, 12'h499,
                   12'h5BF, 12'h692, 12'h782, 12'h800};

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_digits = '0; bus.in_dp = '0; bus.in_blink = '0;
        bus.m_waitrequest = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_m_write", bus.m_write, 0);
        chk("rst_m_address", bus.m_address, 0);
        chk("rst_m_writedata", bus.m_writedata, 0);
        reset = 1'b0;

        // Full first frame with literal expectations.
        run_frame(32'h65A43A21, 8'h00, 8'h00, 0, 1'b0);
        chk("f1_busy", busy_cnt, 18);
        for (int i = 0; i < 9 && i < obs_q.size(); i++) chk("f1_write", obs_q[i], f1_exp[i]);

        run_frame(32'h65A43A21, 8'h00, 8'h00, 0, 1'b0);
        chk("repeat_busy", busy_cnt, 9);
        chk("repeat_writes", obs_q.size(), 0);

        run_frame(32'h75A43A21, 8'h00, 8'h00, 0, 1'b0);
        chk("d7_writes", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("d7_write", obs_q[0], 12'h7F8);

        run_frame(32'h65A43A21, 8'h00, 8'h00, 0, 1'b0);
        run_frame(32'h65A43A21, 8'h02, 8'h03, 0, 1'b0);
        chk("dp_writes", obs_q.size(), 2);
        if (obs_q.size() > 1) begin
            chk("dp_write1", obs_q[0], 12'h124);
            chk("blink_write", obs_q[1], 12'h803);
        end

        // Stall the addr 2 write for three cycles.
        do_reset();
        run_frame(32'h65A43A21, 8'h00, 8'h00, 2, 1'b0);
        chk("stall_a2_cycles", a2_cnt, 4);
        chk("stall_busy", busy_cnt, 21);
        if (obs_q.size() > 3) begin
            chk("stall_a2_once", obs_q[2], 12'h2BF);
            chk("stall_next_a3", obs_q[3][11:8], 3);
        end

        // Reset during the addr 4 write, then the same frame must rewrite everything.
        do_reset();
        run_frame(32'h65A43A21, 8'h00, 8'h00, 0, 1'b1);
        run_frame(32'h65A43A21, 8'h00, 8'h00, 0, 1'b0);
        chk("post_abort_writes", obs_q.size(), 9);

        // Randomized frames: mutate a few nibbles/masks so both skips and writes occur.
        d = 32'h65A43A21; dp = 8'h00; bl = 8'h00;
        for (int f = 0; f < 25; f++) begin
            for (int n = 0; n < 8; n++)
                if ($urandom_range(0, 3) == 0) d[n*4 +: 4] = 4'($urandom);
            if ($urandom_range(0, 2) == 0) dp = 8'($urandom);
            if ($urandom_range(0, 3) == 0) bl = 8'($urandom);
            run_frame(d, dp, bl, 1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
